// File: rtl/z16_dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module     : z16_dmem_arbiter_if
// Description: Bundle of the two requester ports and the data-memory port of
//              the Z16 data-memory arbiter.
//              slave  modport : the arbiter (consumes requests, drives memory)
//              master modport : requesters plus the memory read-data source
//              Requester signals : i_req*, i_lock*, i_wen*, i_addr*, i_wdata*
//              Return signals    : o_gnt*, o_rvalid*, o_rdata
//              Memory signals    : o_mem_addr, o_mem_wen, o_mem_wdata,
//                                  i_mem_rdata
// Revision   : 1.0 - initial release
// ============================================================================
interface z16_dmem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              i_req0;
    logic              i_req1;
    logic              i_lock0;
    logic              i_lock1;
    logic              i_wen0;
    logic              i_wen1;
    logic [ADDR_W-1:0] i_addr0;
    logic [ADDR_W-1:0] i_addr1;
    logic [DATA_W-1:0] i_wdata0;
    logic [DATA_W-1:0] i_wdata1;
    logic              o_gnt0;
    logic              o_gnt1;
    logic              o_rvalid0;
    logic              o_rvalid1;
    logic [DATA_W-1:0] o_rdata;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_wen;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_req0, i_req1, i_lock0, i_lock1, i_wen0, i_wen1,
        input  i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
        output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata,
        output o_mem_addr, o_mem_wen, o_mem_wdata
    );

    modport master (
        output i_req0, i_req1, i_lock0, i_lock1, i_wen0, i_wen1,
        output i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
        input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata,
        input  o_mem_addr, o_mem_wen, o_mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/z16_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : z16_dmem_arbiter
// Description: Shares the single Z16 data memory between requester 0 (CPU
//              load/store) and requester 1 (loader/debug DMA). At most one
//              access is granted per cycle (combinational grant); read data
//              is registered and returned one cycle after the grant. A
//              granted requester may lock the memory for a burst of at most
//              MAX_LOCK consecutive cycles.
//              Ports: i_clk, i_rst_n (async, active-low), bus (slave modport
//              of z16_dmem_arbiter_if: requester and memory signals).
//              Build option: Z16_DMEM_ARB_FIXED_PRIO_EN - when defined, idle
//              ties always go to port 0 instead of round-robin.
// Revision   : 1.0 - initial release
// ============================================================================
module z16_dmem_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_LOCK = 8
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst_n,
    z16_dmem_arbiter_if.slave    bus
);
    localparam int c_CNT_W = $clog2(MAX_LOCK) + 1;
    localparam logic [c_CNT_W-1:0] c_MAX_LOCK = c_CNT_W'(MAX_LOCK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last;      // index of the last granted port
    logic [c_CNT_W-1:0]  r_lock_cnt;  // grants already taken in this burst
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_tie0;
    logic                w_rd_gnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;

`ifdef Z16_DMEM_ARB_FIXED_PRIO_EN
    assign w_tie0 = 1'b1;
`else
    // Port 1 was served last -> port 0 takes the tie.
    assign w_tie0 = r_last;
`endif

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_req0 && (!bus.i_req1 || w_tie0)) begin
                    w_gnt0 = 1'b1;
                end else if (bus.i_req1) begin
                    w_gnt1 = 1'b1;
                end
            end
            LOCK0:   w_gnt0 = bus.i_req0;
            LOCK1:   w_gnt1 = bus.i_req1;
            default: ;
        endcase
        // Grants are suppressed while reset is held so the memory sees no
        // stray access before the first clock edge after release.
        if (!i_rst_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign w_rd_gnt  = (w_gnt0 && !bus.i_wen0) || (w_gnt1 && !bus.i_wen1);
    // The burst including the current grant reaches w_cnt_nxt cycles; when
    // that equals MAX_LOCK this is the last cycle the lock may hold.
    assign w_cnt_nxt = r_lock_cnt + 1'b1;

    assign bus.o_gnt0      = w_gnt0;
    assign bus.o_gnt1      = w_gnt1;
    assign bus.o_mem_addr  = w_gnt0 ? bus.i_addr0  : (w_gnt1 ? bus.i_addr1  : '0);
    assign bus.o_mem_wen   = w_gnt0 ? bus.i_wen0   : (w_gnt1 && bus.i_wen1);
    assign bus.o_mem_wdata = w_gnt0 ? bus.i_wdata0 : (w_gnt1 ? bus.i_wdata1 : '0);
    assign bus.o_rvalid0   = r_rvalid0;
    assign bus.o_rvalid1   = r_rvalid1;
    assign bus.o_rdata     = r_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_lock_cnt <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 && !bus.i_wen0;
            r_rvalid1 <= w_gnt1 && !bus.i_wen1;
            if (w_rd_gnt) begin
                r_rdata <= bus.i_mem_rdata;
            end
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_gnt0 && bus.i_lock0) begin
                        r_state    <= LOCK0;
                        r_lock_cnt <= c_CNT_W'(1);
                    end else if (w_gnt1 && bus.i_lock1) begin
                        r_state    <= LOCK1;
                        r_lock_cnt <= c_CNT_W'(1);
                    end
                end
                LOCK0: begin
                    if (!bus.i_req0 || !bus.i_lock0 || (w_cnt_nxt == c_MAX_LOCK)) begin
                        r_state    <= IDLE;
                        r_lock_cnt <= '0;
                        r_last     <= 1'b0;
                    end else begin
                        r_lock_cnt <= w_cnt_nxt;
                    end
                end
                LOCK1: begin
                    if (!bus.i_req1 || !bus.i_lock1 || (w_cnt_nxt == c_MAX_LOCK)) begin
                        r_state    <= IDLE;
                        r_lock_cnt <= '0;
                        r_last     <= 1'b1;
                    end else begin
                        r_lock_cnt <= w_cnt_nxt;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_lock_cnt <= '0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
